hyperbus_read_ctrl: RTL and testbench
=====================================

Name: hyperbus_read_ctrl

Overview:
- Sequences one HyperBus read burst on the receive side of the uDMA HyperBus controller, in the system clock domain (clk0).
- Accepts a burst request from the transaction engine. Enables the RWDS-gated read clock and the DDR input stage once the command/address phase is done, then counts 16-bit words popped from the read CDC FIFO.
- Forwards the words downstream with valid/ready, closes the read clock after the last word, and reports completion or timeout.

Parameters:
- LEN_W, 16, width of the burst length in 16-bit words.
- TO_W, 10, width of the first-word timeout counter.
- SETTLE_CYC, 4, clk0 cycles between read-clock disable and done (lets the CDC FIFO drain late words).

Ports:
- clk0  in  1  system clock.
- rst_i  in  1  synchronous reset, active-high.
- req_valid_i  in  1  burst request valid.
- req_ready_o  out  1  request accepted (high only in IDLE).
- req_len_i  in  LEN_W  number of words; 0 means 2^LEN_W.
- cfg_timeout_i  in  TO_W  first-word timeout in clk0 cycles; 0 disables the timeout.
- cmd_done_i  in  1  single-cycle pulse from the TX engine: CA phase and latency finished.
- read_clk_en_o  out  1  enables the RWDS read clock gate.
- en_ddr_in_o  out  1  enables the DDR input sampling.
- fifo_valid_i  in  1  CDC FIFO destination valid.
- fifo_data_i  in  16  CDC FIFO destination data.
- fifo_ready_o  out  1  CDC FIFO destination ready (pop).
- rx_valid_o  out  1  downstream word valid.
- rx_data_o  out  16  downstream word.
- rx_last_o  out  1  marks the final word of the burst.
- rx_ready_i  in  1  downstream ready.
- done_o  out  1  single-cycle pulse at burst end.
- timeout_o  out  1  single-cycle pulse, coincident with done_o, when the burst was aborted.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_i sampled high on a clk0 edge):
  - State goes to IDLE; all counters clear.
  - All outputs are 0 except req_ready_o, which is 1.
  - Applies mid-burst too: read_clk_en_o drops the cycle after reset, with no done_o pulse.
- Word path:
  - fifo_ready_o = rx_ready_i AND (state is WAIT or DATA); rx_valid_o = fifo_valid_i under the same state gate.
  - rx_data_o = fifo_data_i, combinational, zero latency, no buffering.
  - A word transfers when fifo_valid_i & fifo_ready_o.
- States:
  - IDLE: req_ready_o=1. On req_valid_i, latch len (0 means 2^LEN_W) into remaining and go to CMD.
  - CMD: wait for cmd_done_i, then go to WAIT. read_clk_en_o=1 and en_ddr_in_o=1 are registered and asserted from the first cycle of WAIT.
  - WAIT: the timeout counter increments each cycle. The first transfer decrements remaining and goes to DATA; if it is also the last word, go straight to SETTLE. If the counter reaches cfg_timeout_i (nonzero) before any word, go to SETTLE with the abort flag set.
  - DATA: each transfer decrements remaining. The transfer with remaining==1 asserts rx_last_o combinationally and moves to SETTLE. There is no timeout in DATA.
  - SETTLE: read_clk_en_o and en_ddr_in_o are 0 and fifo_ready_o is 0. Count SETTLE_CYC cycles, then go to DONE.
  - DONE: one cycle; done_o=1, timeout_o=abort flag. Clear the flag and return to IDLE. A new request is accepted the following cycle, never in DONE.
- Boundary conditions:
  - A cmd_done_i pulse outside CMD is ignored.
  - A timeout match and a first transfer in the same cycle: the transfer wins and no timeout is raised.
  - Words arriving in SETTLE stay in the FIFO. Extra words after the last word are not popped; the TX engine guarantees their absence.
  - Remaining is LEN_W+1 bits so 2^LEN_W is representable; no wrap.

Optional Feature:
- Macro HYPER_READ_STATS_EN.
- With it defined:
  - adds outputs stat_words_o[31:0] and stat_timeouts_o[15:0].
  - Both counters are saturating and cleared by rst_i.
  - stat_words_o counts every word transfer; stat_timeouts_o counts timeout_o pulses.
- Without it, the ports and counters are absent.

Decomposition:
- Package hyperbus_read_pkg holds:
  - the state enum (IDLE, CMD, WAIT, DATA, SETTLE, DONE);
  - the default localparams for LEN_W and TO_W.
- One sub-module, hyperbus_read_timer: loadable down-counter with a zero flag, reused for both the timeout and SETTLE counts.

Test Plan:
- Nominal burst: len=4, cmd_done after 5 cycles, FIFO supplies 4 words with rx_ready=1 -> 4 transfers, rx_last on the 4th, read_clk_en high from WAIT to the 4th word, done_o exactly SETTLE_CYC+1 cycles later, timeout_o=0.
- Backpressure: len=3, rx_ready toggles 1/0 -> fifo_ready_o tracks rx_ready, data order preserved, exactly 3 pops.
- Timeout: cfg_timeout=20, no FIFO words -> read_clk_en drops after 20 WAIT cycles, done_o and timeout_o pulse together, busy_o falls.
- Length zero: len=0 with LEN_W=4 -> 16 words accepted, rx_last on the 16th.
- Reset mid-DATA: rst_i high after 2 of 8 words -> read_clk_en_o=0 and req_ready_o=1 the next cycle, no done_o, and a fresh len=1 burst completes normally.
- Race: first word arrives in the same cycle the timeout matches (cfg_timeout=7) -> word accepted, no timeout_o.

Source files
------------

// File: rtl/hyperbus_read_pkg.sv
// Shared types and default widths for the HyperBus receive-side read sequencer.
package hyperbus_read_pkg;

  localparam int LEN_W_DEF = 16;
  localparam int TO_W_DEF  = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WAIT,
    ST_DATA,
    ST_SETTLE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/hyperbus_read_timer.sv
// Loadable down-counter with a zero flag; shared by the first-word timeout and the settle delay.
module hyperbus_read_timer #(
  parameter int W = 10
) (
  input  logic         clk0,
  input  logic         rst_i,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Holds at zero instead of wrapping so a late decrement is harmless.
  always_ff @(posedge clk0) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hyperbus_read_ctrl.sv
// Sequences one HyperBus read burst in clk0: CA wait, read-clock window, word pop, settle, done.
// Optional macro HYPER_READ_STATS_EN adds saturating word / timeout statistics outputs.
module hyperbus_read_ctrl
  import hyperbus_read_pkg::*;
#(
  parameter int LEN_W      = LEN_W_DEF,
  parameter int TO_W       = TO_W_DEF,
  parameter int SETTLE_CYC = 4
) (
  input  logic             clk0,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [LEN_W-1:0] req_len_i,
  input  logic [TO_W-1:0]  cfg_timeout_i,
  input  logic             cmd_done_i,
  output logic             read_clk_en_o,
  output logic             en_ddr_in_o,
  input  logic             fifo_valid_i,
  input  logic [15:0]      fifo_data_i,
  output logic             fifo_ready_o,
  output logic             rx_valid_o,
  output logic [15:0]      rx_data_o,
  output logic             rx_last_o,
  input  logic             rx_ready_i,
  output logic             done_o,
  output logic             timeout_o,
  output logic             busy_o,
`ifdef HYPER_READ_STATS_EN
  output logic [31:0]      stat_words_o,
  output logic [15:0]      stat_timeouts_o,
`endif
  output state_e           dbg_state_o
);

  localparam logic [TO_W-1:0] SETTLE_LOAD = TO_W'(SETTLE_CYC - 1);

  // Handshake: a word moves when fifo_valid_i & fifo_ready_o; rx_valid_o/rx_ready_i
  // mirror that pair with no buffering, so downstream stalls stall the FIFO directly.
  state_e         state;
  logic [LEN_W:0] remaining;
  logic [LEN_W:0] len_ext;
  logic           rd_active;
  logic           abort;
  logic           to_en;
  logic           xfer;
  logic           last_word;
  logic           tmr_load;
  logic [TO_W-1:0] tmr_val;
  logic           tmr_dec;
  logic           tmr_zero;

  assign len_ext   = (req_len_i == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, req_len_i};
  assign last_word = (remaining == {{LEN_W{1'b0}}, 1'b1});

  assign fifo_ready_o  = rx_ready_i & rd_active;
  assign rx_valid_o    = fifo_valid_i & rd_active;
  assign rx_data_o     = fifo_data_i;
  assign xfer          = fifo_valid_i & fifo_ready_o;
  assign rx_last_o     = xfer & last_word;
  assign read_clk_en_o = rd_active;
  assign en_ddr_in_o   = rd_active;
  assign dbg_state_o   = state;

  // Timer holds cfg_timeout-1 on WAIT entry so the abort lands in WAIT cycle number cfg_timeout.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    case (state)
      ST_CMD: begin
        if (cmd_done_i) begin
          tmr_load = 1'b1;
          tmr_val  = cfg_timeout_i - 1'b1;
        end
      end
      ST_WAIT: begin
        if ((xfer && last_word) || (!xfer && to_en && tmr_zero)) begin
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LOAD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_DATA: begin
        if (xfer && last_word) begin
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LOAD;
        end
      end
      ST_SETTLE: tmr_dec = 1'b1;
      default: ;
    endcase
  end

  hyperbus_read_timer #(.W(TO_W)) u_timer (
    .clk0     (clk0),
    .rst_i    (rst_i),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk0) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      remaining   <= '0;
      rd_active   <= 1'b0;
      abort       <= 1'b0;
      to_en       <= 1'b0;
      req_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      timeout_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            remaining   <= len_ext;
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            state       <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (cmd_done_i) begin
            rd_active <= 1'b1;
            to_en     <= (cfg_timeout_i != '0);
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (xfer) begin
            remaining <= remaining - 1'b1;
            if (last_word) begin
              rd_active <= 1'b0;
              state     <= ST_SETTLE;
            end else begin
              state <= ST_DATA;
            end
          end else if (to_en && tmr_zero) begin
            abort     <= 1'b1;
            rd_active <= 1'b0;
            state     <= ST_SETTLE;
          end
        end
        ST_DATA: begin
          if (xfer) begin
            remaining <= remaining - 1'b1;
            if (last_word) begin
              rd_active <= 1'b0;
              state     <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (tmr_zero) begin
            done_o    <= 1'b1;
            timeout_o <= abort;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          abort       <= 1'b0;
          req_ready_o <= 1'b1;
          busy_o      <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef HYPER_READ_STATS_EN
  always_ff @(posedge clk0) begin
    if (rst_i) begin
      stat_words_o    <= '0;
      stat_timeouts_o <= '0;
    end else begin
      if (xfer && (stat_words_o != '1)) stat_words_o <= stat_words_o + 1'b1;
      if (timeout_o && (stat_timeouts_o != '1)) stat_timeouts_o <= stat_timeouts_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hyperbus_read_ctrl.sv
// Bench for hyperbus_read_ctrl: burst table, hand sequences and randomized bursts vs a cycle-level model.
module tb_hyperbus_read_ctrl;
  import hyperbus_read_pkg::*;

  localparam int LEN_W  = 4;
  localparam int TO_W   = 10;
  localparam int SETTLE = 4;
  localparam int MAXC   = 256;

  logic             clk0 = 1'b0;
  logic             rst_i = 1'b1;
  logic             req_valid_i = 1'b0;
  logic             req_ready_o;
  logic [LEN_W-1:0] req_len_i = '0;
  logic [TO_W-1:0]  cfg_timeout_i = '0;
  logic             cmd_done_i = 1'b0;
  logic             read_clk_en_o;
  logic             en_ddr_in_o;
  logic             fifo_valid_i = 1'b0;
  logic [15:0]      fifo_data_i = '0;
  logic             fifo_ready_o;
  logic             rx_valid_o;
  logic [15:0]      rx_data_o;
  logic             rx_last_o;
  logic             rx_ready_i = 1'b0;
  logic             done_o;
  logic             timeout_o;
  logic             busy_o;
  state_e           dbg_state_o;
`ifdef HYPER_READ_STATS_EN
  logic [31:0]      stat_words_o;
  logic [15:0]      stat_timeouts_o;
`endif

  always #5 clk0 = ~clk0;

  hyperbus_read_ctrl #(.LEN_W(LEN_W), .TO_W(TO_W), .SETTLE_CYC(SETTLE)) dut (
    .clk0          (clk0),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_len_i     (req_len_i),
    .cfg_timeout_i (cfg_timeout_i),
    .cmd_done_i    (cmd_done_i),
    .read_clk_en_o (read_clk_en_o),
    .en_ddr_in_o   (en_ddr_in_o),
    .fifo_valid_i  (fifo_valid_i),
    .fifo_data_i   (fifo_data_i),
    .fifo_ready_o  (fifo_ready_o),
    .rx_valid_o    (rx_valid_o),
    .rx_data_o     (rx_data_o),
    .rx_last_o     (rx_last_o),
    .rx_ready_i    (rx_ready_i),
    .done_o        (done_o),
    .timeout_o     (timeout_o),
    .busy_o        (busy_o),
`ifdef HYPER_READ_STATS_EN
    .stat_words_o    (stat_words_o),
    .stat_timeouts_o (stat_timeouts_o),
`endif
    .dbg_state_o   (dbg_state_o)
  );

  typedef struct {
    int len;
    int cfg;
    int cmd_dly;
    int first;
    int rdy_mode;
    int vld_mode;
    int exp_words;
    bit exp_to;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];
  bit vld_p[0:MAXC];
  bit rdy_p[0:MAXC];
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk0);
    #1;
  endtask

  // Cycle c (1 = first WAIT cycle): FIFO has a word when vld_p[c], downstream accepts when rdy_p[c].
  task automatic gen_patterns(input int first, input int rdy_mode, input int vld_mode);
    for (int c = 0; c <= MAXC; c++) begin
      case (rdy_mode)
        0: rdy_p[c] = 1'b1;
        1: rdy_p[c] = (c % 2) == 1;
        default: rdy_p[c] = ($urandom_range(0, 3) != 0);
      endcase
      vld_p[c] = (c > first) && (vld_mode == 0 || $urandom_range(0, 3) != 0);
    end
  endtask

  // Outcome from the burst rules: abort iff the timeout is enabled and no word can move by cycle cfg.
  task automatic predict(input int len, input int cfg, output int words, output bit to);
    int f;
    f = MAXC + 1;
    for (int c = MAXC; c >= 1; c--) if (vld_p[c] && rdy_p[c]) f = c;
    to    = (cfg != 0) && (f > cfg);
    words = to ? 0 : ((len == 0) ? (1 << LEN_W) : len);
  endtask

  task automatic run_burst(input int len, input int cfg, input int cmd_dly,
                           input int exp_words, input bit exp_to);
    int len_eff, pops, dut_words, c, w;
    bit fin;
    len_eff = (len == 0) ? (1 << LEN_W) : len;
    exp_q.delete();
    for (int i = 0; i < len_eff; i++) exp_q.push_back(16'($urandom));
    w = 0;
    while (!req_ready_o && w < 20) begin step(); w++; end
    chk("req_ready_before", req_ready_o, 1);
    req_valid_i   = 1'b1;
    req_len_i     = len[LEN_W-1:0];
    cfg_timeout_i = cfg[TO_W-1:0];
    step();
    req_valid_i = 1'b0;
    chk("busy_in_cmd", busy_o, 1);
    chk("req_ready_in_cmd", req_ready_o, 0);
    for (int i = 0; i < cmd_dly; i++) begin
      fifo_valid_i = 1'b1;
      rx_ready_i   = 1'b1;
      #1;
      chk("read_clk_en_cmd", read_clk_en_o, 0);
      chk("fifo_ready_cmd", fifo_ready_o, 0);
      step();
    end
    cmd_done_i = 1'b1;
    step();
    cmd_done_i = 1'b0;
    pops = 0; dut_words = 0; c = 0; fin = 1'b0;
    while (!fin && c < MAXC) begin
      c++;
      fifo_valid_i = vld_p[c];
      rx_ready_i   = rdy_p[c];
      fifo_data_i  = (exp_q.size() > 0) ? exp_q[0] : 16'($urandom);
      #1;
      chk("read_clk_en", read_clk_en_o, 1);
      chk("en_ddr_in", en_ddr_in_o, 1);
      chk("fifo_ready", fifo_ready_o, rdy_p[c]);
      chk("rx_valid", rx_valid_o, vld_p[c]);
      if (fifo_valid_i && fifo_ready_o) dut_words++;
      if (vld_p[c] && rdy_p[c]) begin
        chk("rx_data", rx_data_o, exp_q.pop_front());
        chk("rx_last", rx_last_o, (pops + 1) == len_eff);
        pops++;
        if (pops == len_eff) fin = 1'b1;
      end else if (pops == 0 && cfg != 0 && c == cfg) begin
        fin = 1'b1;
      end
      step();
    end
    if (!fin) chk("burst_bound", 0, 1);
    for (int s = 0; s < SETTLE; s++) begin
      fifo_valid_i = 1'b1;
      rx_ready_i   = 1'b1;
      #1;
      chk("settle_clk_en", read_clk_en_o, 0);
      chk("settle_fifo_ready", fifo_ready_o, 0);
      chk("settle_done", done_o, 0);
      chk("settle_busy", busy_o, 1);
      step();
    end
    fifo_valid_i = 1'b0;
    chk("done_pulse", done_o, 1);
    chk("timeout_pulse", timeout_o, exp_to);
    chk("req_ready_in_done", req_ready_o, 0);
    chk("words", dut_words, exp_words);
    step();
    chk("idle_ready", req_ready_o, 1);
    chk("idle_busy", busy_o, 0);
    chk("idle_done", done_o, 0);
    chk("idle_timeout", timeout_o, 0);
  endtask

  initial begin
    int ew, rl, rc;
    bit et;
    tbl[0] = '{len: 4, cfg: 0,  cmd_dly: 5, first: 0,    rdy_mode: 0, vld_mode: 0, exp_words: 4,  exp_to: 0};
    tbl[1] = '{len: 3, cfg: 0,  cmd_dly: 2, first: 0,    rdy_mode: 1, vld_mode: 0, exp_words: 3,  exp_to: 0};
    tbl[2] = '{len: 4, cfg: 20, cmd_dly: 3, first: 1000, rdy_mode: 0, vld_mode: 0, exp_words: 0,  exp_to: 1};
    tbl[3] = '{len: 0, cfg: 0,  cmd_dly: 1, first: 2,    rdy_mode: 0, vld_mode: 0, exp_words: 16, exp_to: 0};
    tbl[4] = '{len: 1, cfg: 7,  cmd_dly: 2, first: 6,    rdy_mode: 0, vld_mode: 0, exp_words: 1,  exp_to: 0};
    tbl[5] = '{len: 2, cfg: 7,  cmd_dly: 0, first: 7,    rdy_mode: 0, vld_mode: 0, exp_words: 0,  exp_to: 1};
    tbl[6] = '{len: 2, cfg: 1,  cmd_dly: 1, first: 1,    rdy_mode: 0, vld_mode: 0, exp_words: 0,  exp_to: 1};
    tbl[7] = '{len: 5, cfg: 3,  cmd_dly: 4, first: 0,    rdy_mode: 1, vld_mode: 0, exp_words: 5,  exp_to: 0};

    step(); step(); step();
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_clk_en", read_clk_en_o, 0);
    chk("rst_en_ddr", en_ddr_in_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_state", dbg_state_o, ST_IDLE);
    rst_i = 1'b0;
    step();

    // A cmd_done pulse in IDLE must not start anything.
    cmd_done_i = 1'b1;
    step();
    cmd_done_i = 1'b0;
    chk("stray_cmd_ready", req_ready_o, 1);
    chk("stray_cmd_clk_en", read_clk_en_o, 0);
    chk("stray_cmd_busy", busy_o, 0);

    foreach (tbl[i]) begin
      gen_patterns(tbl[i].first, tbl[i].rdy_mode, tbl[i].vld_mode);
      run_burst(tbl[i].len, tbl[i].cfg, tbl[i].cmd_dly, tbl[i].exp_words, tbl[i].exp_to);
    end

    // Reset in the middle of an 8-word burst after two words.
    req_valid_i = 1'b1; req_len_i = 4'd8; cfg_timeout_i = '0;
    step();
    req_valid_i = 1'b0;
    cmd_done_i = 1'b1;
    step();
    cmd_done_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fifo_valid_i = 1'b1; rx_ready_i = 1'b1; fifo_data_i = 16'($urandom);
      #1;
      chk("mid_fifo_ready", fifo_ready_o, 1);
      step();
    end
    fifo_valid_i = 1'b0;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("mid_rst_clk_en", read_clk_en_o, 0);
    chk("mid_rst_ready", req_ready_o, 1);
    chk("mid_rst_done", done_o, 0);
    for (int i = 0; i < SETTLE + 3; i++) begin
      step();
      chk("mid_rst_no_done", done_o, 0);
    end
    gen_patterns(0, 0, 0);
    run_burst(1, 0, 2, 1, 0);

    for (int r = 0; r < 12; r++) begin
      rl = $urandom_range(0, 15);
      rc = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 30);
      gen_patterns($urandom_range(0, 35), 2, 1);
      predict(rl, rc, ew, et);
      run_burst(rl, rc, $urandom_range(0, 6), ew, et);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
